// File: rtl/pulse_gen_pkg.sv
// Shared types for the multi-channel pulse generator: per-channel FSM state
// encoding and the mode constants.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/pulse_channel.sv
// One pulse-generator channel: IDLE/RUN/DONE FSM plus an N-bit period counter.
// The terminal test uses the live ticks value, so shrinking the period below
// the current count ends the period at once instead of wrapping.
module pulse_channel
  import pulse_gen_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena_i,
  input  logic [N-1:0] ticks_i,
  input  logic         mode_i,
  input  logic         trigger_i,
  input  logic         sync_i,
  output logic         out_o,
  output logic         busy_o
);

  state_e       state_q;
  logic [N-1:0] cnt_q;
  logic         mode_q;
  logic         out_q;
  logic         busy_q;

  logic [N-1:0] lim;
  logic         term;

  // Last count of a period; ticks of 0 behaves like 1.
  assign lim  = (ticks_i == '0) ? '0 : (ticks_i - N'(1));
  // A sync strobe in RUN suppresses the terminal event of that cycle.
  assign term = (cnt_q >= lim) && !sync_i;

  // Channel FSM with counter; out/busy registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_PERIODIC;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      out_q <= 1'b0;
      if (!ena_i) begin
        // Disable wins everywhere and cancels any pending pulse.
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (mode_i == MODE_PERIODIC || trigger_i) begin
              state_q <= RUN;
              cnt_q   <= '0;
              mode_q  <= mode_i;
              busy_q  <= 1'b1;
            end
          end
          RUN: begin
            if (sync_i) begin
              cnt_q <= '0;
            end else if (term) begin
              cnt_q <= '0;
              out_q <= 1'b1;
              if (mode_q == MODE_ONESHOT) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + N'(1);
            end
          end
          DONE: begin
            // Re-arm only once trigger has been released.
            if (!trigger_i) state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_o  = out_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// CH independent programmable pulse generators.
// Optional feature: define PULSE_GEN_SYNC_EN to add the global 'sync' input,
// which re-phases every running channel to counter 0 in the same cycle.
module multi_pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef PULSE_GEN_SYNC_EN
  input  logic                 sync,
`endif
  input  logic [CH-1:0]        ena,
  input  logic [CH-1:0][N-1:0] ticks,
  input  logic [CH-1:0]        mode,
  input  logic [CH-1:0]        trigger,
  output logic [CH-1:0]        out,
  output logic [CH-1:0]        busy
);

  logic sync_w;

`ifdef PULSE_GEN_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  for (genvar g = 0; g < CH; g++) begin : g_ch
    pulse_channel #(.N(N)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ena_i     (ena[g]),
      .ticks_i   (ticks[g]),
      .mode_i    (mode[g]),
      .trigger_i (trigger[g]),
      .sync_i    (sync_w),
      .out_o     (out[g]),
      .busy_o    (busy[g])
    );
  end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Self-checking bench for multi_pulse_generator (N=8, CH=4). Edge numbering in
// the scenarios is relative to the edge on which a channel enters RUN (edge 0).
module tb_multi_pulse_generator;
  localparam int N  = 8;
  localparam int CH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sync = 1'b0;
  logic [CH-1:0]        ena = '0, mode = '0, trigger = '0;
  logic [CH-1:0][N-1:0] ticks = '0;
  logic [CH-1:0]        out, busy;

  int n_chk = 0;
  int n_pass = 0;

  // behavioural model: per channel, running/done flags and elapsed cycles
  bit m_run[CH], m_done[CH], m_one[CH];
  int m_el[CH];
  logic [CH-1:0] m_out, m_busy;

  always #5 clk = ~clk;

  multi_pulse_generator #(.N(N), .CH(CH)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef PULSE_GEN_SYNC_EN
    .sync    (sync),
`endif
    .ena     (ena),
    .ticks   (ticks),
    .mode    (mode),
    .trigger (trigger),
    .out     (out),
    .busy    (busy)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ena = '0; mode = '0; trigger = '0; ticks = '0; sync = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_done[c] = 0; m_one[c] = 0; m_el[c] = 0;
    end
    m_out = '0; m_busy = '0;
  endtask

  // One clock of the spec rules using the inputs applied before the edge.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      int eff;
      eff = (ticks[c] == 0) ? 1 : int'(ticks[c]);
      m_out[c] = 1'b0;
      if (!ena[c]) begin
        m_run[c] = 0; m_done[c] = 0; m_el[c] = 0;
      end else if (!m_run[c] && !m_done[c]) begin
        if (!mode[c] || trigger[c]) begin
          m_run[c] = 1; m_one[c] = mode[c]; m_el[c] = 0;
        end
      end else if (m_run[c]) begin
        if (m_el[c] + 1 >= eff) begin
          m_out[c] = 1'b1; m_el[c] = 0;
          if (m_one[c]) begin m_run[c] = 0; m_done[c] = 1; end
        end else begin
          m_el[c]++;
        end
      end else if (!trigger[c]) begin
        m_done[c] = 0;
      end
      m_busy[c] = m_run[c];
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({out, busy} !== '0) $display("FAIL reset_outputs got=%h exp=0", {out, busy});
    else n_pass++;
    ena = '1; ticks = {CH{8'd3}};
    repeat (2) tick();
    n_chk++;
    if (busy !== '0) $display("FAIL reset_hold_busy got=%h exp=0", busy);
    else n_pass++;
    rst = 1'b1;
    tick();                                   // edge 0: entry
    n_chk++;
    if (busy !== '1) $display("FAIL reset_release_busy got=%h exp=f", busy);
    else n_pass++;
    tick();                                   // edge 1, mid-period
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({out, busy} !== '0) $display("FAIL reset_async_midrun got=%h exp=0", {out, busy});
    else n_pass++;
    rst = 1'b1;
    tick();                                   // re-entry edge 0
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_chk++;
      if (out !== ((k == 3) ? 4'hf : 4'h0))
        $display("FAIL reset_reentry_pulse k=%0d got=%h exp=%h", k, out, (k == 3) ? 4'hf : 4'h0);
      else n_pass++;
    end
  endtask

  task automatic test_periodic();
    do_reset();
    ticks[0] = 8'd5; ena[0] = 1'b1;
    tick();
    n_chk++;
    if (busy[0] !== 1'b1) $display("FAIL periodic_busy got=%b exp=1", busy[0]);
    else n_pass++;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_chk++;
      if (out[0] !== (k % 5 == 0)) $display("FAIL periodic_out k=%0d got=%b exp=%b", k, out[0], (k % 5 == 0));
      else n_pass++;
    end
  endtask

  task automatic test_small_ticks();
    do_reset();
    ticks[0] = 8'd0; ticks[1] = 8'd1; ena = 4'b0011;
    tick();
    n_chk++;
    if (out[1:0] !== 2'b00) $display("FAIL small_ticks_entry got=%b exp=00", out[1:0]);
    else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_chk++;
      if (out[1:0] !== 2'b11) $display("FAIL small_ticks_out k=%0d got=%b exp=11", k, out[1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    int pulses, first;
    do_reset();
    ena[2] = 1'b1; mode[2] = 1'b1; ticks[2] = 8'd3;
    tick();
    n_chk++;
    if (busy[2] !== 1'b0) $display("FAIL oneshot_armed_busy got=%b exp=0", busy[2]);
    else n_pass++;
    trigger[2] = 1'b1;
    pulses = 0; first = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out[2]) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    n_chk++;
    if (pulses !== 1 || first !== 3) $display("FAIL oneshot_single got=%0d@%0d exp=1@3", pulses, first);
    else n_pass++;
    trigger[2] = 1'b0;
    tick();
    trigger[2] = 1'b1;
    tick();                                   // re-entry edge 0
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_chk++;
      if (out[2] !== (k == 3)) $display("FAIL oneshot_rearm k=%0d got=%b exp=%b", k, out[2], (k == 3));
      else n_pass++;
    end
  endtask

  task automatic test_ticks_change();
    int pulses;
    do_reset();
    ena[3] = 1'b1; ticks[3] = 8'd200;
    tick();                                   // edge 0
    pulses = 0;
    for (int k = 1; k <= 100; k++) begin tick(); if (out[3]) pulses++; end
    ticks[3] = 8'd50;
    tick();                                   // edge 101
    n_chk++;
    if (pulses !== 0 || out[3] !== 1'b1) $display("FAIL shrink_terminal got=%0d,%b exp=0,1", pulses, out[3]);
    else n_pass++;
    pulses = 0;
    for (int k = 102; k <= 150; k++) begin tick(); if (out[3]) pulses++; end
    tick();                                   // edge 151
    n_chk++;
    if (pulses !== 0 || out[3] !== 1'b1) $display("FAIL shrink_period got=%0d,%b exp=0,1", pulses, out[3]);
    else n_pass++;
    for (int k = 152; k <= 200; k++) tick();
    ena[3] = 1'b0;                            // would have been terminal
    tick();
    n_chk++;
    if ({out[3], busy[3]} !== 2'b00) $display("FAIL disable_cancel got=%b exp=00", {out[3], busy[3]});
    else n_pass++;
  endtask

  task automatic test_max_ticks();
    int pulses;
    do_reset();
    ena[1] = 1'b1; ticks[1] = 8'd255;
    tick();
    pulses = 0;
    for (int k = 1; k < 255; k++) begin tick(); if (out[1]) pulses++; end
    tick();                                   // edge 255
    n_chk++;
    if (pulses !== 0 || out[1] !== 1'b1) $display("FAIL max_ticks got=%0d,%b exp=0,1", pulses, out[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < CH; c++) ticks[c] = 8'($urandom_range(0, 9));
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 15) == 0) ena[c] = ~ena[c];
        else if ($urandom_range(0, 7) == 0) ena[c] = 1'b1;
        if ($urandom_range(0, 19) == 0) ticks[c] = 8'($urandom_range(0, 9));
        if ($urandom_range(0, 29) == 0) mode[c] = ~mode[c];
        if ($urandom_range(0, 3) == 0) trigger[c] = ~trigger[c];
      end
      tick();
      model_step();
      n_chk++;
      if ({out, busy} !== {m_out, m_busy})
        $display("FAIL random_cycle i=%0d got=%h/%h exp=%h/%h", i, out, busy, m_out, m_busy);
      else n_pass++;
    end
  endtask

`ifdef PULSE_GEN_SYNC_EN
  task automatic test_sync();
    do_reset();
    ticks = {CH{8'd7}};
    for (int c = 0; c < CH; c++) begin ena[c] = 1'b1; tick(); end
    repeat (3) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_chk++;
      if (out !== ((k == 7) ? 4'hf : 4'h0))
        $display("FAIL sync_align k=%0d got=%h exp=%h", k, out, (k == 7) ? 4'hf : 4'h0);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_periodic();
    test_small_ticks();
    test_oneshot();
    test_ticks_change();
    test_max_ticks();
    test_random();
`ifdef PULSE_GEN_SYNC_EN
    test_sync();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
